fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decode/control unit.
- Holds the PC and issues one read at a time to instruction memory, which has variable latency.
- Presents the fetched word plus its PC to decode over a valid/ready handshake.
- Computes the next PC from the decoded branch decision (PCsrc) and the sign-extended immediate (ImmOp).

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decode/control unit.
// Holds the PC, issues one instruction-memory read at a time (variable latency),
// buffers the returned word with its PC and hands it to decode over valid/ready.
// The next PC comes from the branch decision (PCsrc) and the immediate (ImmOp)
// sampled in the handshake cycle; a misaligned target parks the unit in a
// terminal fault state until reset.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   stall                freezes the decode handshake (and therefore the PC)
//   PCsrc, ImmOp         branch taken / sign-extended offset for presented instr
//   imem_req, imem_addr  one-cycle read request and its address (address = PC)
//   imem_rdata/valid     read response
//   instr, instr_pc      buffered instruction and its PC
//   instr_valid/ready    handshake to decode
//   fault                sticky misaligned-target flag
//   fetch_count          instructions accepted by decode, modulo 2^32
module fetch_unit #(
   parameter int unsigned             DATA_WIDTH = 32,
   parameter int unsigned             ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  PCsrc,
   input  logic [DATA_WIDTH-1:0] ImmOp,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  imem_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic                  fault,
   output logic [31:0]           fetch_count
);

   typedef enum logic [1:0] {StIssue, StWait, StHold, StFault} state_e;

   state_e                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_instr;
   logic [ADDR_WIDTH-1:0] r_instr_pc;
   logic                  r_valid;
   logic                  r_req;
   logic                  r_fault;
   logic [31:0]           r_count;

   logic                  w_fire;
   logic [ADDR_WIDTH-1:0] w_imm;
   logic [ADDR_WIDTH-1:0] w_target;

   assign w_fire   = (r_state == StHold) && instr_ready && !stall;
   // Signed cast sign-extends or truncates the offset to the address width.
   assign w_imm    = ADDR_WIDTH'($signed(ImmOp));
   assign w_target = PCsrc ? (r_instr_pc + w_imm) : (r_instr_pc + ADDR_WIDTH'(4));

   // Reset leaves the FSM in ISSUE with the request low, so the first request
   // goes out one cycle after reset release. Entering ISSUE from HOLD raises
   // the request immediately to keep the 3-cycle loop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIssue;
         r_pc       <= RESET_PC;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_req      <= 1'b0;
         r_fault    <= 1'b0;
         r_count    <= '0;
      end else begin
         case (r_state)
            StIssue: begin
               if (!r_req) begin
                  r_req <= 1'b1;
               end else begin
                  r_req   <= 1'b0;
                  r_state <= StWait;
               end
            end
            StWait: begin
               if (imem_valid) begin
                  r_instr    <= imem_rdata;
                  r_instr_pc <= r_pc;
                  r_valid    <= 1'b1;
                  r_state    <= StHold;
               end
            end
            StHold: begin
               if (w_fire) begin
                  r_count <= r_count + 32'd1;
                  r_valid <= 1'b0;
                  if (w_target[1:0] == 2'b00) begin
                     r_pc    <= w_target;
                     r_req   <= 1'b1;
                     r_state <= StIssue;
                  end else begin
                     r_fault <= 1'b1;
                     r_state <= StFault;
                  end
               end
            end
            StFault: begin
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
            default: r_state <= StFault;
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_valid;
   assign fault       = r_fault;
   assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table of fetch/branch transactions
// followed by hand-written sequences for backpressure, latency, fault and reset.
module tb_fetch_unit;

   localparam logic [31:0] Key = 32'h1357_9BDF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        PCsrc = 1'b0;
   logic [31:0] ImmOp = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] mem_rdata = '0;
   logic        mem_valid = 1'b0;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        fault;
   logic [31:0] fetch_count;

   logic        d2_req;
   logic [31:0] d2_addr;
   logic [31:0] d2_instr;
   logic [31:0] d2_instr_pc;
   logic        d2_valid;
   logic        d2_fault;
   logic [31:0] d2_count;

   int n_vec = 0;
   int n_err = 0;

   // memory model state
   int          lat = 1;
   int          cnt = 0;
   logic [31:0] addr_l = '0;
   logic        spur = 1'b0;

   fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .PCsrc(PCsrc), .ImmOp(ImmOp),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(mem_rdata),
      .imem_valid(mem_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .fault(fault),
      .fetch_count(fetch_count)
   );

   // Wrap instance: runs in lockstep with dut since it sees the same inputs.
   fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .stall(stall), .PCsrc(PCsrc), .ImmOp(ImmOp),
      .imem_req(d2_req), .imem_addr(d2_addr), .imem_rdata(mem_rdata),
      .imem_valid(mem_valid), .instr(d2_instr), .instr_pc(d2_instr_pc),
      .instr_valid(d2_valid), .instr_ready(instr_ready), .fault(d2_fault),
      .fetch_count(d2_count)
   );

   always #5 clk = ~clk;

   // Memory: answers a request seen at negedge after 'lat' cycles with addr^Key.
   initial begin
      forever begin
         @(negedge clk or posedge rst);
         if (rst) begin
            cnt       = 0;
            mem_valid = 1'b0;
         end else begin
            mem_valid = 1'b0;
            if (spur) begin
               mem_valid = 1'b1;
               mem_rdata = 32'hDEAD_BEEF;
               spur      = 1'b0;
            end else if (cnt > 0) begin
               cnt = cnt - 1;
               if (cnt == 0) begin
                  mem_valid = 1'b1;
                  mem_rdata = addr_l ^ Key;
               end
            end
            if (imem_req) begin
               cnt    = lat;
               addr_l = imem_addr;
            end
         end
      end
   end

   typedef struct {
      logic        pcsrc;
      logic [31:0] imm;
      logic [31:0] exp_pc;
      logic [31:0] exp_next;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input logic [31:0] exp_pc);
      int k = 0;
      while (!instr_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("instr_valid_timeout", {31'd0, instr_valid}, 32'd1);
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_data", instr, exp_pc ^ Key);
   endtask

   task automatic fire(input logic pcsrc, input logic [31:0] imm);
      instr_ready = 1'b1;
      PCsrc       = pcsrc;
      ImmOp       = imm;
      @(negedge clk);
      instr_ready = 1'b0;
      PCsrc       = 1'b0;
      ImmOp       = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h0,         32'h00, 32'h04, 32'd1};
      vecs[1] = '{1'b0, 32'h0,         32'h04, 32'h08, 32'd2};
      vecs[2] = '{1'b0, 32'h0,         32'h08, 32'h0C, 32'd3};
      vecs[3] = '{1'b0, 32'h0,         32'h0C, 32'h10, 32'd4};
      vecs[4] = '{1'b1, 32'hFFFF_FFF8, 32'h10, 32'h08, 32'd5};
      vecs[5] = '{1'b1, 32'hFFFF_FFF8, 32'h08, 32'h00, 32'd6};
      vecs[6] = '{1'b0, 32'h0,         32'h00, 32'h04, 32'd7};
      vecs[7] = '{1'b0, 32'h0,         32'h04, 32'h08, 32'd8};
      vecs[8] = '{1'b1, 32'h10,        32'h08, 32'h18, 32'd9};
      vecs[9] = '{1'b1, 32'hFFFF_FFE8, 32'h18, 32'h00, 32'd10};

      // Reset values
      @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'd0);
      chk("wrap_first_addr", d2_addr, 32'hFFFF_FFFC);

      // Vector table: fetch, handshake, check the following request
      for (int i = 0; i < 10; i++) begin
         wait_valid(vecs[i].exp_pc);
         fire(vecs[i].pcsrc, vecs[i].imm);
         chk("next_req", {31'd0, imem_req}, 32'd1);
         chk("next_addr", imem_addr, vecs[i].exp_next);
         chk("valid_drop", {31'd0, instr_valid}, 32'd0);
         chk("count", fetch_count, vecs[i].exp_cnt);
         if (i == 0) chk("wrap_second_addr", d2_addr, 32'h0);
      end

      // Backpressure with instr_ready low, then with stall high
      do_reset();
      wait_valid(32'h0);
      fire(1'b0, 32'h0);
      wait_valid(32'h4);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, instr_valid}, 32'd1);
         chk("bp_pc", instr_pc, 32'h4);
         chk("bp_instr", instr, 32'h4 ^ Key);
         chk("bp_req", {31'd0, imem_req}, 32'd0);
      end
      fire(1'b0, 32'h0);
      chk("bp_next_req", {31'd0, imem_req}, 32'd1);
      chk("bp_next_addr", imem_addr, 32'h8);
      wait_valid(32'h8);
      stall       = 1'b1;
      instr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("st_valid", {31'd0, instr_valid}, 32'd1);
         chk("st_pc", instr_pc, 32'h8);
         chk("st_req", {31'd0, imem_req}, 32'd0);
         chk("st_count", fetch_count, 32'd2);
      end
      stall = 1'b0;
      lat   = 4;
      fire(1'b0, 32'h0);
      chk("st_next_addr", imem_addr, 32'hC);

      // Variable latency: response four cycles after the request
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("lat_valid", {31'd0, instr_valid}, (k == 5) ? 32'd1 : 32'd0);
         chk("lat_no_req", {31'd0, imem_req}, 32'd0);
      end
      chk("lat_pc", instr_pc, 32'hC);
      spur = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("spur_instr", instr, 32'hC ^ Key);
         chk("spur_req", {31'd0, imem_req}, 32'd0);
      end
      lat = 1;

      // Misaligned branch target
      fire(1'b0, 32'h0);
      wait_valid(32'h10);
      fire(1'b1, 32'h6);
      chk("flt_fault", {31'd0, fault}, 32'd1);
      chk("flt_valid", {31'd0, instr_valid}, 32'd0);
      chk("flt_count", fetch_count, 32'd5);
      for (int k = 0; k < 8; k++) begin
         instr_ready = 1'b1;
         @(negedge clk);
         chk("flt_req", {31'd0, imem_req}, 32'd0);
         chk("flt_hold_count", fetch_count, 32'd5);
      end
      instr_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("flt_rst_fault", {31'd0, fault}, 32'd0);
      chk("flt_rst_count", fetch_count, 32'd0);
      chk("flt_rst_addr", imem_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      wait_valid(32'h0);

      // Reset during WAIT takes effect without a clock edge
      lat = 4;
      fire(1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_req", {31'd0, imem_req}, 32'd0);
      chk("mid_valid", {31'd0, instr_valid}, 32'd0);
      chk("mid_instr", instr, 32'd0);
      chk("mid_instr_pc", instr_pc, 32'd0);
      chk("mid_count", fetch_count, 32'd0);
      chk("mid_addr", imem_addr, 32'd0);
      @(negedge clk);
      lat = 1;
      rst = 1'b0;
      wait_valid(32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
